serial_subtractor: RTL and testbench

//   Bit-serial subtractor: diff = a - b - bin over WIDTH-bit operands.

---
 rtl/serial_subtractor.sv | 110 +++++++++++
 tb/tb_serial_subtractor.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin, one full-subtractor stage reused LSB first.
// Result registers update only on the completion edge; latency WIDTH+1 edges from start.
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state, state_next;
    logic             load;
    logic [WIDTH-1:0] a_sr, b_sr, d_sr;
    logic [CW-1:0]    cnt;
    logic             br, br_next;
    logic             x, y, d;

    // One full-subtractor slice, fed from the low ends of the shift registers.
    assign x       = a_sr[0];
    assign y       = b_sr[0];
    assign d       = x ^ y ^ br;
    assign br_next = (~x & y) | (~(x ^ y) & br);

    assign busy = (state == RUN);
    assign done = (state == DONE);

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (cnt == LAST) state_next = DONE;
            end
            DONE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_sr <= '0;
            b_sr <= '0;
            d_sr <= '0;
            br   <= 1'b0;
            cnt  <= '0;
            diff <= '0;
            bout <= 1'b0;
            ovf  <= 1'b0;
        end else if (load) begin
            a_sr <= a;
            b_sr <= b;
            d_sr <= '0;
            br   <= bin;
            cnt  <= '0;
        end else if (state == RUN) begin
            a_sr <= {1'b0, a_sr[WIDTH-1:1]};
            b_sr <= {1'b0, b_sr[WIDTH-1:1]};
            d_sr <= {d, d_sr[WIDTH-1:1]};
            br   <= br_next;
            cnt  <= cnt + CW'(1);
            if (cnt == LAST) begin
                diff <= {d, d_sr[WIDTH-1:1]};
                bout <= br_next;
                // During the MSB stage br still holds the borrow into the MSB.
                ovf  <= br ^ br_next;
            end
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=4): directed vectors plus an
// exhaustive sweep against an arithmetic reference model.
module tb_serial_subtractor;

    localparam int WIDTH = 4;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             start = 1'b0;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             bin = 1'b0;
    logic             busy, done, bout, ovf;
    logic [WIDTH-1:0] diff;

    int n_tests = 0;
    int n_fail  = 0;

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .start  (start),
        .a      (a),
        .b      (b),
        .bin    (bin),
        .busy   (busy),
        .done   (done),
        .diff   (diff),
        .bout   (bout),
        .ovf    (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Request on the next edge; returns at the negedge of the first RUN cycle
    // with the operand pins scrambled so late sampling would be visible.
    task automatic start_op(input logic [3:0] ta, input logic [3:0] tb, input logic tbin);
        @(negedge clk);
        a = ta; b = tb; bin = tbin; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = ~ta; b = ~tb; bin = ~tbin;
    endtask

    // Wait (bounded) for done, counting cycles and busy cycles observed before it.
    task automatic wait_done(input string tag, output int cycles, output int nbusy);
        cycles = 0;
        nbusy  = 0;
        while (!done && cycles < 20) begin
            if (busy) nbusy++;
            @(negedge clk);
            cycles++;
        end
        check({tag, "_done_seen"}, 32'(done), 32'd1);
    endtask

    task automatic check_result(input string tag, input logic [3:0] ed, input logic eb, input logic eo);
        check({tag, "_diff"}, 32'(diff), 32'(ed));
        check({tag, "_bout"}, 32'(bout), 32'(eb));
        check({tag, "_ovf"},  32'(ovf),  32'(eo));
    endtask

    task automatic directed(input string tag, input logic [3:0] ta, input logic [3:0] tb, input logic tbin,
                            input logic [3:0] ed, input logic eb, input logic eo);
        int cyc, nb;
        start_op(ta, tb, tbin);
        wait_done(tag, cyc, nb);
        check_result(tag, ed, eb, eo);
        @(negedge clk);
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        int cyc, nb, done_seen;
        logic [4:0] full;
        int sr;
        logic eovf;

        // Reset state
        #12;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_res",  32'({bout, ovf, diff}), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // 1: basic op, latency and busy length
        start_op(4'd7, 4'd2, 1'b0);
        wait_done("t1", cyc, nb);
        check("t1_latency", 32'(cyc), 32'(WIDTH));
        check("t1_busy_cycles", 32'(nb), 32'(WIDTH));
        check_result("t1", 4'd5, 1'b0, 1'b0);
        @(negedge clk);
        check("t1_done_pulse", 32'(done), 32'd0);
        check("t1_hold_diff", 32'(diff), 32'd5);

        // 2/3: borrow and overflow boundaries
        directed("t2a", 4'd3, 4'd5, 1'b0, 4'hE, 1'b1, 1'b0);
        directed("t2b", 4'd0, 4'd0, 1'b1, 4'hF, 1'b1, 1'b0);
        directed("t3a", 4'd8, 4'd1, 1'b0, 4'd7, 1'b0, 1'b1);
        directed("t3b", 4'd7, 4'hF, 1'b0, 4'd8, 1'b1, 1'b1);

        // 4: start during RUN ignored; back-to-back start from DONE
        start_op(4'd7, 4'd2, 1'b0);
        a = 4'd1; b = 4'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("t4_busy_mid", 32'(busy), 32'd1);
        check("t4_diff_not_mid", 32'(diff), 32'd8);
        wait_done("t4a", cyc, nb);
        check_result("t4a", 4'd5, 1'b0, 1'b0);
        a = 4'd6; b = 4'd6; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = 4'd9; b = 4'd2;
        check("t4_b2b_busy", 32'(busy), 32'd1);
        wait_done("t4b", cyc, nb);
        check("t4b_latency", 32'(cyc), 32'(WIDTH));
        check_result("t4b", 4'd0, 1'b0, 1'b0);

        // 5: asynchronous reset mid-RUN
        @(negedge clk);
        directed("t5a", 4'd7, 4'd2, 1'b0, 4'd5, 1'b0, 1'b0);
        start_op(4'd3, 4'd1, 1'b0);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("t5_rst_busy", 32'(busy), 32'd0);
        check("t5_rst_done", 32'(done), 32'd0);
        check("t5_rst_res",  32'({bout, ovf, diff}), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        done_seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        check("t5_no_done", 32'(done_seen), 32'd0);
        directed("t5b", 4'd3, 4'd1, 1'b0, 4'd2, 1'b0, 1'b0);

        // 6: exhaustive sweep against the reference model
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                for (int ic = 0; ic < 2; ic++) begin
                    full = 5'(ia) - 5'(ib) - 5'(ic);
                    sr   = ((ia > 7) ? ia - 16 : ia) - ((ib > 7) ? ib - 16 : ib) - ic;
                    eovf = (sr > 7) || (sr < -8);
                    start_op(4'(ia), 4'(ib), 1'(ic));
                    wait_done("ex", cyc, nb);
                    check($sformatf("ex_%0d_%0d_%0d", ia, ib, ic),
                          32'({bout, ovf, diff}), 32'({full[4], eovf, full[3:0]}));
                    @(negedge clk);
                    check("ex_done_once", 32'(done), 32'd0);
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
